// File: rtl/char_latch_seq.sv
// Write-side sequencer for the video terminal character latch: PIA handshake,
// latch load, screen-memory write at the cursor slot, and clear-screen. Optional macro: LOWER_FOLD_EN.
module char_latch_seq #(
  parameter int COLS       = 40,
  parameter int CLR_FRAMES = 2
) (
  input  logic       clk,
  input  logic       mr,
  input  logic [6:0] char_in,
  input  logic       char_stb,
  input  logic       clr_btn,
  input  logic       cursor_slot,
  input  logic       frame_start,
  output logic       rda,
  output logic [5:0] latch_d,
  output logic       latch_load,
  output logic       latch_clr_n,
  output logic       mem_we,
  output logic       cur_adv,
  output logic       cur_cr,
  output logic       cur_home,
  output logic       clr_active
);

  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [3:0]       CNT_LAST = 4'(CLR_FRAMES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_SLOT, S_ADVANCE, S_CR_WAIT, S_CLR_SYNC, S_CLR_RUN
  } state_t;

  function automatic logic [6:0] fold_char(input logic [6:0] c);
`ifdef LOWER_FOLD_EN
    if (c >= 7'h61 && c <= 7'h7A) return c - 7'h20;
`endif
    return c;
  endfunction

  function automatic logic is_print(input logic [6:0] c);
    return (c >= 7'h20) && (c <= 7'h7E);
  endfunction

  state_t           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             clr_q;
  logic             rda_q, rda_d;
  logic [5:0]       latch_d_q, latch_d_d;
  logic             latch_load_q, latch_load_d;
  logic             latch_clr_n_q, latch_clr_n_d;
  logic             mem_we_q, mem_we_d;
  logic             cur_adv_q, cur_adv_d;
  logic             cur_cr_q, cur_cr_d;
  logic             cur_home_q, cur_home_d;
  logic             clr_active_q, clr_active_d;

  logic [6:0] ch;
  logic       clr_edge;
  logic       accept;

  assign ch       = fold_char(char_in);
  assign clr_edge = clr_btn & ~clr_q;
  // A character is taken only while ready is being shown; a clear edge in the same cycle drops it.
  assign accept   = (state_q == S_IDLE) && rda_q && char_stb && !clr_edge;

  always_ff @(posedge clk or posedge mr) begin
    if (mr) begin
      state_q       <= S_IDLE;
      col_q         <= '0;
      cnt_q         <= '0;
      clr_q         <= 1'b0;
      rda_q         <= 1'b0;
      latch_d_q     <= '0;
      latch_load_q  <= 1'b0;
      latch_clr_n_q <= 1'b0;
      mem_we_q      <= 1'b0;
      cur_adv_q     <= 1'b0;
      cur_cr_q      <= 1'b0;
      cur_home_q    <= 1'b0;
      clr_active_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      cnt_q         <= cnt_d;
      clr_q         <= clr_btn;
      rda_q         <= rda_d;
      latch_d_q     <= latch_d_d;
      latch_load_q  <= latch_load_d;
      latch_clr_n_q <= latch_clr_n_d;
      mem_we_q      <= mem_we_d;
      cur_adv_q     <= cur_adv_d;
      cur_cr_q      <= cur_cr_d;
      cur_home_q    <= cur_home_d;
      clr_active_q  <= clr_active_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    if (clr_edge) begin
      state_d = S_CLR_SYNC;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept && is_print(ch))  state_d = S_WAIT_SLOT;
          else if (accept && ch == 7'h0D) state_d = S_CR_WAIT;
        end
        S_WAIT_SLOT: if (cursor_slot) state_d = S_ADVANCE;
        S_ADVANCE: begin
          state_d = S_IDLE;
          col_d   = (col_q == COL_LAST) ? '0 : col_q + COL_W'(1);
        end
        S_CR_WAIT: begin
          if (cursor_slot) begin
            state_d = S_IDLE;
            col_d   = '0;
          end
        end
        S_CLR_SYNC: begin
          if (frame_start) begin
            state_d = S_CLR_RUN;
            cnt_d   = '0;
          end
        end
        S_CLR_RUN: begin
          if (frame_start) begin
            if (cnt_q == CNT_LAST) begin
              state_d = S_IDLE;
              col_d   = '0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    rda_d         = (state_d == S_IDLE) && !accept;
    latch_d_d     = latch_d_q;
    latch_load_d  = 1'b0;
    if (accept && is_print(ch)) begin
      latch_d_d    = ch[5:0];
      latch_load_d = 1'b1;
    end
    latch_clr_n_d = !clr_edge;
    mem_we_d      = !clr_edge && (state_q == S_WAIT_SLOT) && cursor_slot;
    cur_adv_d     = !clr_edge && (state_q == S_ADVANCE) && (col_q != COL_LAST);
    cur_cr_d      = !clr_edge && (((state_q == S_ADVANCE) && (col_q == COL_LAST)) ||
                                  ((state_q == S_CR_WAIT) && cursor_slot));
    cur_home_d    = !clr_edge && (state_q == S_CLR_RUN) && frame_start && (cnt_q == CNT_LAST);
    clr_active_d  = (state_d == S_CLR_RUN);
  end

  assign rda         = rda_q;
  assign latch_d     = latch_d_q;
  assign latch_load  = latch_load_q;
  assign latch_clr_n = latch_clr_n_q;
  assign mem_we      = mem_we_q;
  assign cur_adv     = cur_adv_q;
  assign cur_cr      = cur_cr_q;
  assign cur_home    = cur_home_q;
  assign clr_active  = clr_active_q;

endmodule

// File: tb/tb_char_latch_seq.sv
// Self-checking bench for char_latch_seq: directed scenarios plus randomized characters
// checked against a column/classification model.
module tb_char_latch_seq;
  localparam int COLS = 40;
  localparam int CLR_FRAMES = 2;

  logic clk = 1'b0;
  logic mr = 1'b1;
  logic [6:0] char_in = '0;
  logic char_stb = 1'b0, clr_btn = 1'b0, cursor_slot = 1'b0, frame_start = 1'b0;
  logic rda, latch_load, latch_clr_n, mem_we, cur_adv, cur_cr, cur_home, clr_active;
  logic [5:0] latch_d;

  char_latch_seq #(.COLS(COLS), .CLR_FRAMES(CLR_FRAMES)) dut (
    .clk(clk), .mr(mr), .char_in(char_in), .char_stb(char_stb), .clr_btn(clr_btn),
    .cursor_slot(cursor_slot), .frame_start(frame_start), .rda(rda), .latch_d(latch_d),
    .latch_load(latch_load), .latch_clr_n(latch_clr_n), .mem_we(mem_we), .cur_adv(cur_adv),
    .cur_cr(cur_cr), .cur_home(cur_home), .clr_active(clr_active)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  int exp_col = 0;
  int n_load = 0, n_we = 0, n_adv = 0, n_cr = 0, n_home = 0;
  logic [5:0] last_d = '0;

  always @(negedge clk) begin
    if (latch_load) begin n_load++; last_d = latch_d; end
    if (mem_we)   n_we++;
    if (cur_adv)  n_adv++;
    if (cur_cr)   n_cr++;
    if (cur_home) n_home++;
  end

  function automatic int ref_kind(input int c);
    if (c == 13) return 2;
    if (c >= 32 && c <= 126) return 1;
    return 0;
  endfunction

  function automatic logic [5:0] ref_code(input int c);
    int f;
    f = c;
`ifdef LOWER_FOLD_EN
    if (c >= 97 && c <= 122) f = c - 32;
`endif
    return 6'(f % 64);
  endfunction

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic do_char(input int c, input int dly, output bit ok, output logic r0, output logic r1);
    int t;
    t = 0;
    ok = 1'b1;
    while (rda !== 1'b1 && t < 50) begin step; t++; end
    if (rda !== 1'b1) ok = 1'b0;
    char_in = 7'(c); char_stb = 1'b1;
    step;
    r0 = rda; char_stb = 1'b0;
    if (dly == 0) begin
      cursor_slot = 1'b1; step; r1 = rda; cursor_slot = 1'b0;
    end else begin
      step; r1 = rda;
      repeat (dly - 1) step;
      cursor_slot = 1'b1; step; cursor_slot = 1'b0;
    end
    repeat (3) step;
  endtask

  task automatic test_reset;
    int we0;
    repeat (3) step;
    n_cmp++; if ({rda, latch_load, latch_clr_n, mem_we, cur_adv, cur_cr, cur_home, clr_active, latch_d} !== 14'h0) begin
      n_fail++; $display("FAIL reset_hold outputs=%h want 0", {rda, latch_load, latch_clr_n, mem_we, cur_adv, cur_cr, cur_home, clr_active, latch_d}); end
    mr = 1'b0; step;
    n_cmp++; if ({rda, latch_clr_n} !== 2'b11) begin n_fail++; $display("FAIL reset_release rda,clr_n=%b want 11", {rda, latch_clr_n}); end
    char_in = 7'h41; char_stb = 1'b1; step; char_stb = 1'b0; step;
    mr = 1'b1; #1;
    n_cmp++; if ({rda, latch_load, latch_clr_n, mem_we, cur_adv, cur_cr, cur_home, clr_active, latch_d} !== 14'h0) begin
      n_fail++; $display("FAIL reset_mid outputs=%h want 0", {rda, latch_load, latch_clr_n, mem_we, cur_adv, cur_cr, cur_home, clr_active, latch_d}); end
    step;
    n_cmp++; if ({rda, latch_clr_n, mem_we} !== 3'b000) begin n_fail++; $display("FAIL reset_mid_hold got %b want 000", {rda, latch_clr_n, mem_we}); end
    mr = 1'b0; step;
    n_cmp++; if ({rda, latch_clr_n} !== 2'b11) begin n_fail++; $display("FAIL reset_rerelease rda,clr_n=%b want 11", {rda, latch_clr_n}); end
    we0 = n_we;
    cursor_slot = 1'b1; step; cursor_slot = 1'b0; repeat (3) step;
    n_cmp++; if (n_we - we0 !== 0) begin n_fail++; $display("FAIL reset_no_we got %0d want 0", n_we - we0); end
    exp_col = 0;
  endtask

  task automatic test_char;
    char_in = 7'h41; char_stb = 1'b1; step; char_stb = 1'b0;
    n_cmp++; if ({rda, latch_load} !== 2'b01) begin n_fail++; $display("FAIL char_e0 rda,load=%b want 01", {rda, latch_load}); end
    n_cmp++; if (latch_d !== 6'h01) begin n_fail++; $display("FAIL char_latch_d got %h want 01", latch_d); end
    step;
    n_cmp++; if ({latch_load, mem_we} !== 2'b00) begin n_fail++; $display("FAIL char_load_once load,we=%b want 00", {latch_load, mem_we}); end
    repeat (3) step;
    cursor_slot = 1'b1; step; cursor_slot = 1'b0;
    n_cmp++; if ({mem_we, cur_adv, rda} !== 3'b100) begin n_fail++; $display("FAIL char_we we,adv,rda=%b want 100", {mem_we, cur_adv, rda}); end
    step;
    n_cmp++; if ({mem_we, cur_adv, cur_cr, rda} !== 4'b0101) begin n_fail++; $display("FAIL char_adv we,adv,cr,rda=%b want 0101", {mem_we, cur_adv, cur_cr, rda}); end
    step;
    n_cmp++; if (cur_adv !== 1'b0) begin n_fail++; $display("FAIL char_adv_once got %b want 0", cur_adv); end
    exp_col = 1;
  endtask

  task automatic test_cr_bel;
    int l0, w0, a0, c0;
    bit ok; logic r0, r1;
    l0 = n_load; w0 = n_we; a0 = n_adv; c0 = n_cr;
    do_char(13, 3, ok, r0, r1);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL cr_rda_timeout got %b want 1", ok); end
    n_cmp++; if ({n_load - l0, n_we - w0, n_adv - a0, n_cr - c0} !== {32'd0, 32'd0, 32'd0, 32'd1}) begin
      n_fail++; $display("FAIL cr_pulses load=%0d we=%0d adv=%0d cr=%0d want 0 0 0 1", n_load - l0, n_we - w0, n_adv - a0, n_cr - c0); end
    exp_col = 0;
    l0 = n_load; w0 = n_we; a0 = n_adv; c0 = n_cr;
    do_char(7, 2, ok, r0, r1);
    n_cmp++; if ({r0, r1} !== 2'b01) begin n_fail++; $display("FAIL bel_rda got %b want 01", {r0, r1}); end
    n_cmp++; if ({n_load - l0, n_we - w0, n_adv - a0, n_cr - c0} !== {32'd0, 32'd0, 32'd0, 32'd0}) begin
      n_fail++; $display("FAIL bel_pulses load=%0d we=%0d adv=%0d cr=%0d want 0", n_load - l0, n_we - w0, n_adv - a0, n_cr - c0); end
  endtask

  task automatic test_row;
    int a0, c0, a1, c1;
    bit ok; logic r0, r1;
    a0 = n_adv; c0 = n_cr;
    for (int i = 0; i < COLS; i++) begin
      a1 = n_adv; c1 = n_cr;
      do_char(7'h58, $urandom_range(0, 3), ok, r0, r1);
      n_cmp++; if ({n_adv - a1, n_cr - c1} !== ((exp_col == COLS - 1) ? {32'd0, 32'd1} : {32'd1, 32'd0})) begin
        n_fail++; $display("FAIL row_char%0d adv=%0d cr=%0d col=%0d", i, n_adv - a1, n_cr - c1, exp_col); end
      exp_col = (exp_col == COLS - 1) ? 0 : exp_col + 1;
    end
    n_cmp++; if ({n_adv - a0, n_cr - c0} !== {32'(COLS - 1), 32'd1}) begin
      n_fail++; $display("FAIL row_totals adv=%0d cr=%0d want %0d 1", n_adv - a0, n_cr - c0, COLS - 1); end
  endtask

  task automatic test_fold;
    bit ok; logic r0, r1;
    logic [5:0] want;
`ifdef LOWER_FOLD_EN
    want = 6'h01;
`else
    want = 6'h21;
`endif
    do_char(7'h61, 1, ok, r0, r1);
    n_cmp++; if (last_d !== want) begin n_fail++; $display("FAIL fold_a latch_d=%h want %h", last_d, want); end
    exp_col = (exp_col == COLS - 1) ? 0 : exp_col + 1;
  endtask

  task automatic run_frames(input string tag);
    for (int k = 1; k <= CLR_FRAMES + 1; k++) begin
      repeat (4) step;
      frame_start = 1'b1; step; frame_start = 1'b0;
      if (k <= CLR_FRAMES) begin
        n_cmp++; if ({clr_active, cur_home, rda} !== 3'b100) begin n_fail++; $display("FAIL %s_frame%0d act,home,rda=%b want 100", tag, k, {clr_active, cur_home, rda}); end
      end else begin
        n_cmp++; if ({clr_active, cur_home, rda} !== 3'b011) begin n_fail++; $display("FAIL %s_done act,home,rda=%b want 011", tag, {clr_active, cur_home, rda}); end
      end
    end
    step;
    n_cmp++; if (cur_home !== 1'b0) begin n_fail++; $display("FAIL %s_home_once got %b want 0", tag, cur_home); end
  endtask

  task automatic test_clear;
    int l0, w0, a0, h0;
    frame_start = 1'b1; step; frame_start = 1'b0;
    n_cmp++; if (clr_active !== 1'b0) begin n_fail++; $display("FAIL clr_fs_idle got %b want 0", clr_active); end
    l0 = n_load; w0 = n_we; h0 = n_home;
    char_in = 7'h41; char_stb = 1'b1; clr_btn = 1'b1; step; char_stb = 1'b0;
    n_cmp++; if ({latch_clr_n, rda, latch_load} !== 3'b000) begin n_fail++; $display("FAIL clr_edge clr_n,rda,load=%b want 000", {latch_clr_n, rda, latch_load}); end
    step;
    n_cmp++; if ({latch_clr_n, rda, clr_active} !== 3'b100) begin n_fail++; $display("FAIL clr_sync clr_n,rda,act=%b want 100", {latch_clr_n, rda, clr_active}); end
    cursor_slot = 1'b1; step; cursor_slot = 1'b0; step;
    run_frames("clr");
    repeat (3) step;
    n_cmp++; if ({rda, latch_clr_n} !== 2'b11) begin n_fail++; $display("FAIL clr_no_retrigger rda,clr_n=%b want 11", {rda, latch_clr_n}); end
    n_cmp++; if ({n_load - l0, n_we - w0, n_home - h0} !== {32'd0, 32'd0, 32'd1}) begin
      n_fail++; $display("FAIL clr_pulses load=%0d we=%0d home=%0d want 0 0 1", n_load - l0, n_we - w0, n_home - h0); end
    clr_btn = 1'b0; step;
    exp_col = 0;
    w0 = n_we; a0 = n_adv; h0 = n_home;
    char_in = 7'h5A; char_stb = 1'b1; step; char_stb = 1'b0; step;
    clr_btn = 1'b1; step; clr_btn = 1'b0;
    cursor_slot = 1'b1; step; cursor_slot = 1'b0; repeat (3) step;
    n_cmp++; if ({n_we - w0, n_adv - a0} !== {32'd0, 32'd0}) begin n_fail++; $display("FAIL clr_abort we=%0d adv=%0d want 0 0", n_we - w0, n_adv - a0); end
    run_frames("abort");
    n_cmp++; if (n_home - h0 !== 1) begin n_fail++; $display("FAIL abort_home got %0d want 1", n_home - h0); end
    exp_col = 0;
  endtask

  task automatic test_random;
    int c, r, kind, l0, w0, a0, c0;
    bit ok; logic r0, r1;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 7);
      if (r == 0) c = 13;
      else if (r == 1) c = ($urandom_range(0, 1) == 1) ? 127 : $urandom_range(0, 31);
      else c = $urandom_range(32, 126);
      kind = ref_kind(c);
      l0 = n_load; w0 = n_we; a0 = n_adv; c0 = n_cr;
      do_char(c, $urandom_range(0, 6), ok, r0, r1);
      n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_rda_timeout got %b want 1", i, ok); end
      n_cmp++; if ({n_load - l0, n_we - w0} !== ((kind == 1) ? {32'd1, 32'd1} : {32'd0, 32'd0})) begin
        n_fail++; $display("FAIL rnd%0d_write c=%h load=%0d we=%0d kind=%0d", i, c, n_load - l0, n_we - w0, kind); end
      n_cmp++; if ({n_adv - a0, n_cr - c0} !== {32'((kind == 1) && (exp_col != COLS - 1)),
                                                 32'(((kind == 1) && (exp_col == COLS - 1)) || (kind == 2))}) begin
        n_fail++; $display("FAIL rnd%0d_cursor c=%h adv=%0d cr=%0d col=%0d", i, c, n_adv - a0, n_cr - c0, exp_col); end
      if (kind == 1) begin
        n_cmp++; if (last_d !== ref_code(c)) begin n_fail++; $display("FAIL rnd%0d_code c=%h got %h want %h", i, c, last_d, ref_code(c)); end
        exp_col = (exp_col == COLS - 1) ? 0 : exp_col + 1;
      end else if (kind == 2) begin
        exp_col = 0;
      end else begin
        n_cmp++; if ({r0, r1} !== 2'b01) begin n_fail++; $display("FAIL rnd%0d_ignored_rda c=%h got %b want 01", i, c, {r0, r1}); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_char;
    test_cr_bel;
    test_row;
    test_fold;
    test_clear;
    test_row;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
